pending_encoder_32x5: RTL and testbench
=======================================

# pending_encoder_32x5

Encodes 32 sticky request lines into a 5-bit index, the reverse of the register-file write-enable decode path. Used wherever many one-hot event sources must be funnelled into one indexed consumer, such as trap/interrupt-level selection and register-select feedback. Requests are latched into a pending register, and the highest-priority pending bit is offered with a Valid/Ack handshake. An accepted index is cleared from the pending register.

## Interface
- WIDTH, 32, number of request lines; fixed at 32 in this release so the index stays 5 bits.
- HIGH_FIRST, 1, priority direction: 1 means the highest set index wins; 0 means the lowest set index wins.
- Clk  input  1  rising-edge clock; the only clock.
- Clr  input  1  reset; synchronous, active-low.
- Req  input  32  request pulses or levels; each bit is OR-ed into the pending register every cycle.
- Ack  input  1  consumer accepts the current offer; meaningful only while Valid=1.
- Eout  output  5  offered index; registered.
- Valid  output  1  an offer is present; registered.
- Pend  output  32  current pending register.
- Drop  output  1  one-cycle pulse: a Req bit hit an already-pending bit that is not being cleared this cycle, so the request was coalesced.
- Mask  input  32  present only with ENC_MASK_EN; 1 means the line is eligible.

## Operation
- Reset (Clr=0 at an edge): Pend=0, Eout=0, Valid=0, Drop=0, state=IDLE. Reset overrides Req and Ack in the same cycle.
- Pending update, every edge: Pend_next = (Pend & ~clr_vec) | Req.
  - clr_vec is one-hot at Eout when state=OFFER and Ack=1; otherwise clr_vec is 0.
  - Set wins: if Req hits the bit being cleared, that bit stays pending.
- Drop_next = |(Req & Pend & ~clr_vec).
- Eligible vector: elig = Pend (or Pend & Mask with ENC_MASK_EN).
- FSM:
  - IDLE: if elig≠0, then Eout ← priority_encode(elig), Valid ← 1, go to OFFER. Otherwise hold, with Valid=0 and Eout holding its last value.
  - OFFER: Eout and Valid are frozen regardless of new higher-priority requests or Mask changes. When Ack=1, clear Pend[Eout], set Valid ← 0, go to IDLE. When Ack=0, stay.
- Ack while Valid=0 is ignored.
- An Ack'd bit whose Req is still asserted is re-offered after the normal IDLE cycle.

## Timing
- Req asserted in cycle N: the bit is visible on Pend in cycle N+1, and Valid/Eout in cycle N+2.
- Ack sampled high in cycle M: Valid=0 and the Pend bit is cleared in cycle M+1. The next offer, if elig≠0, appears in cycle M+2.
- Maximum throughput is 1 grant per 2 cycles.
- Drop is asserted the cycle after the coalescing Req.
- Reset asserted mid-offer drops the offer; nothing is reported.

## Configuration
- ENC_MASK_EN defined: the Mask port exists and gates eligibility only.
  - Masked bits still accumulate in Pend and still generate Drop.
  - A Mask change during OFFER does not retract the offer.
- ENC_MASK_EN undefined: no Mask port; all bits are eligible.

## Structure
- Package enc_pkg contains:
  - the state typedef enum {IDLE, OFFER};
  - localparams ENC_WIDTH=32 and ENC_IDXW=5.
- Sub-module pri_enc_32x5: combinational priority encoder with parameter HIGH_FIRST.
  - Inputs: in[31:0]. Outputs: idx[4:0] and any.
  - Instantiated once on elig.

## Test plan
- Reset: hold Clr=0 with Req=32'hFFFFFFFF for 2 cycles, then release with Req=0 -> Pend=0, Valid=0, Eout=0, Drop=0.
- Single request: Req=32'h00000020 for 1 cycle (N) -> Pend=32'h20 at N+1; Valid=1, Eout=5 at N+2. Ack at N+3 -> Valid=0, Pend=0 at N+4.
- Multiple pending, HIGH_FIRST=1: Req=32'h80000011 pulse, with Ack asserted whenever Valid=1 -> Eout sequence 31, 4, 0, spaced 2 cycles apart. With HIGH_FIRST=0, the sequence is 0, 4, 31.
- Frozen offer and coalescing:
  - While Eout=4 is offered with Ack=0, pulse Req=32'h00100000 -> Eout stays 4, Pend gains bit 20. Ack -> Eout=20 offered 2 cycles later.
  - Repeat Req bit 20 while it is pending -> Drop=1 for one cycle.
- Set-wins: in the same cycle as Ack on Eout=7, Req=32'h80 -> Pend bit 7 stays 1, Drop=0, and 7 is re-offered after the IDLE cycle.
- ENC_MASK_EN: Mask=32'hFFFFFFEF with Pend=32'h10 -> Valid stays 0 for 10 cycles. Set Mask=32'hFFFFFFFF -> Valid=1, Eout=4 one cycle later.

Source files
------------

// File: rtl/pending_encoder_32x5_pkg.sv
// Shared types and sizes for the 32-to-5 pending-request encoder.
// Optional masking is enabled with the ENC_MASK_EN macro.
package enc_pkg;

    localparam int ENC_WIDTH = 32;
    localparam int ENC_IDXW  = 5;

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

endpackage

// File: rtl/pending_encoder_32x5_if.sv
// Request/offer bundle between event sources, consumer and encoder.
// ENC_MASK_EN adds the per-line eligibility Mask signal.
interface pending_encoder_32x5_if;
    import enc_pkg::*;

    logic [ENC_WIDTH-1:0] Req;
    logic                 Ack;
    logic [ENC_IDXW-1:0]  Eout;
    logic                 Valid;
    logic [ENC_WIDTH-1:0] Pend;
    logic                 Drop;
`ifdef ENC_MASK_EN
    logic [ENC_WIDTH-1:0] Mask;
`endif

`ifdef ENC_MASK_EN
    modport master (
        output Req, Ack, Mask,
        input  Eout, Valid, Pend, Drop
    );
    modport slave (
        input  Req, Ack, Mask,
        output Eout, Valid, Pend, Drop
    );
`else
    modport master (
        output Req, Ack,
        input  Eout, Valid, Pend, Drop
    );
    modport slave (
        input  Req, Ack,
        output Eout, Valid, Pend, Drop
    );
`endif

endinterface

// File: rtl/pending_encoder_32x5_pri_enc.sv
// Combinational 32-line priority encoder.
// HIGH_FIRST=1 picks the highest set bit, 0 the lowest.
module pri_enc_32x5 #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic [31:0] in,
    output logic [4:0]  idx,
    output logic        any
);

    // Scan order makes the last match the winner.
    always_comb begin
        idx = '0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < 32; i++) begin
                if (in[i]) idx = 5'(i);
            end
        end else begin
            for (int i = 31; i >= 0; i--) begin
                if (in[i]) idx = 5'(i);
            end
        end
        any = |in;
    end

endmodule

// File: rtl/pending_encoder_32x5.sv
// Sticky 32-line request register with prioritised Valid/Ack offer.
// Define ENC_MASK_EN to gate eligibility with the Mask input.
module pending_encoder_32x5
    import enc_pkg::*;
#(
    parameter int WIDTH      = ENC_WIDTH,
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic                    Clk,
    input  logic                    Clr,
    pending_encoder_32x5_if.slave   bus
);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      pend_q, pend_d;
    logic [ENC_IDXW-1:0]   eout_q, eout_d;
    logic                  valid_q, valid_d;
    logic                  drop_q, drop_d;

    logic [WIDTH-1:0]      clr_vec;
    logic [WIDTH-1:0]      elig;
    logic [ENC_IDXW-1:0]   enc_idx;
    logic                  enc_any;

    // Accepted index leaves the pending set; a same-cycle Req wins.
    always_comb begin
        clr_vec = '0;
        if (state_q == OFFER && bus.Ack) clr_vec[eout_q] = 1'b1;
        pend_d = (pend_q & ~clr_vec) | bus.Req;
        drop_d = |(bus.Req & pend_q & ~clr_vec);
    end

    // Lines that may be offered this cycle.
    always_comb begin
`ifdef ENC_MASK_EN
        elig = pend_q & bus.Mask;
`else
        elig = pend_q;
`endif
    end

    pri_enc_32x5 #(
        .HIGH_FIRST (HIGH_FIRST)
    ) u_pri_enc (
        .in  (elig),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Offer FSM: the offer is frozen until it is accepted.
    always_comb begin
        state_d = state_q;
        eout_d  = eout_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (enc_any) begin
                    eout_d  = enc_idx;
                    valid_d = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (bus.Ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Clr) begin
            state_q <= IDLE;
            pend_q  <= '0;
            eout_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            eout_q  <= eout_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.Eout  = eout_q;
    assign bus.Valid = valid_q;
    assign bus.Pend  = pend_q;
    assign bus.Drop  = drop_q;

endmodule

// File: tb/tb_pending_encoder_32x5.sv
// Directed bench: per-cycle vector table plus hand sequences.
// The mask sequence runs only when ENC_MASK_EN is defined.
module tb_pending_encoder_32x5;
    import enc_pkg::*;

    logic Clk = 1'b0;
    logic Clr;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    pending_encoder_32x5_if a ();
    pending_encoder_32x5_if b ();

    pending_encoder_32x5 #(.HIGH_FIRST(1'b1)) dut_hi (
        .Clk (Clk),
        .Clr (Clr),
        .bus (a)
    );

    pending_encoder_32x5 #(.HIGH_FIRST(1'b0)) dut_lo (
        .Clk (Clk),
        .Clr (Clr),
        .bus (b)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        clr;
        logic [31:0] req;
        logic        ack;
        logic [31:0] pend;
        logic        valid;
        logic [4:0]  eout;
        logic        drop;
    } vec_t;

    localparam int NV = 34;
    vec_t tbl [NV];

    function automatic vec_t mk(logic c, logic [31:0] r, logic k,
                                logic [31:0] p, logic v,
                                logic [4:0] e, logic d);
        vec_t t;
        t.clr = c; t.req = r; t.ack = k;
        t.pend = p; t.valid = v; t.eout = e; t.drop = d;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    initial begin
        int lo_exp [3];
        int last;
        int waited;

        // clr, req, ack -> pend, valid, eout, drop (after the edge)
        tbl[0]  = mk(0, 32'hFFFFFFFF, 0, 32'h0, 0, 0, 0);
        tbl[1]  = mk(0, 32'hFFFFFFFF, 0, 32'h0, 0, 0, 0);
        tbl[2]  = mk(1, 32'h0, 0, 32'h0, 0, 0, 0);
        tbl[3]  = mk(1, 32'h20, 0, 32'h20, 0, 0, 0);
        tbl[4]  = mk(1, 32'h0, 0, 32'h20, 1, 5, 0);
        tbl[5]  = mk(1, 32'h0, 1, 32'h0, 0, 5, 0);
        tbl[6]  = mk(1, 32'h0, 0, 32'h0, 0, 5, 0);
        tbl[7]  = mk(1, 32'h80000011, 0, 32'h80000011, 0, 5, 0);
        tbl[8]  = mk(1, 32'h0, 0, 32'h80000011, 1, 31, 0);
        tbl[9]  = mk(1, 32'h0, 1, 32'h00000011, 0, 31, 0);
        tbl[10] = mk(1, 32'h0, 0, 32'h00000011, 1, 4, 0);
        tbl[11] = mk(1, 32'h0, 1, 32'h00000001, 0, 4, 0);
        tbl[12] = mk(1, 32'h0, 0, 32'h00000001, 1, 0, 0);
        tbl[13] = mk(1, 32'h0, 1, 32'h0, 0, 0, 0);
        tbl[14] = mk(1, 32'h10, 0, 32'h10, 0, 0, 0);
        tbl[15] = mk(1, 32'h0, 0, 32'h10, 1, 4, 0);
        tbl[16] = mk(1, 32'h00100000, 0, 32'h00100010, 1, 4, 0);
        tbl[17] = mk(1, 32'h00100000, 0, 32'h00100010, 1, 4, 1);
        tbl[18] = mk(1, 32'h0, 0, 32'h00100010, 1, 4, 0);
        tbl[19] = mk(1, 32'h0, 1, 32'h00100000, 0, 4, 0);
        tbl[20] = mk(1, 32'h0, 0, 32'h00100000, 1, 20, 0);
        tbl[21] = mk(1, 32'h0, 1, 32'h0, 0, 20, 0);
        tbl[22] = mk(1, 32'h80, 0, 32'h80, 0, 20, 0);
        tbl[23] = mk(1, 32'h0, 0, 32'h80, 1, 7, 0);
        tbl[24] = mk(1, 32'h80, 1, 32'h80, 0, 7, 0);
        tbl[25] = mk(1, 32'h0, 0, 32'h80, 1, 7, 0);
        tbl[26] = mk(1, 32'h0, 1, 32'h0, 0, 7, 0);
        tbl[27] = mk(1, 32'h2, 1, 32'h2, 0, 7, 0);
        tbl[28] = mk(1, 32'h0, 1, 32'h2, 1, 1, 0);
        tbl[29] = mk(1, 32'h0, 1, 32'h0, 0, 1, 0);
        tbl[30] = mk(1, 32'h4, 0, 32'h4, 0, 1, 0);
        tbl[31] = mk(1, 32'h0, 0, 32'h4, 1, 2, 0);
        tbl[32] = mk(0, 32'h0, 0, 32'h0, 0, 0, 0);
        tbl[33] = mk(1, 32'h0, 0, 32'h0, 0, 0, 0);

        Clr = 1'b0;
        a.Req = '0; a.Ack = 1'b0;
        b.Req = '0; b.Ack = 1'b0;
`ifdef ENC_MASK_EN
        a.Mask = '1;
        b.Mask = '1;
`endif

        for (int i = 0; i < NV; i++) begin
            @(negedge Clk);
            Clr   = tbl[i].clr;
            a.Req = tbl[i].req;
            a.Ack = tbl[i].ack;
            @(posedge Clk);
            #1;
            chk($sformatf("pend[%0d]", i), a.Pend, tbl[i].pend);
            chk($sformatf("valid[%0d]", i), 32'(a.Valid), 32'(tbl[i].valid));
            chk($sformatf("eout[%0d]", i), 32'(a.Eout), 32'(tbl[i].eout));
            chk($sformatf("drop[%0d]", i), 32'(a.Drop), 32'(tbl[i].drop));
        end

        @(negedge Clk);
        a.Req = '0; a.Ack = 1'b0;

        // Low-first instance drains the same burst in ascending order.
        lo_exp[0] = 0; lo_exp[1] = 4; lo_exp[2] = 31;
        last = 0;
        @(negedge Clk);
        b.Req = 32'h80000011;
        @(negedge Clk);
        b.Req = '0;
        for (int g = 0; g < 3; g++) begin
            waited = 0;
            do begin
                @(posedge Clk);
                #1;
                waited++;
            end while (!b.Valid && waited < 8);
            chk($sformatf("lo_valid[%0d]", g), 32'(b.Valid), 32'd1);
            chk($sformatf("lo_eout[%0d]", g), 32'(b.Eout), 32'(lo_exp[g]));
            if (g > 0) chk($sformatf("lo_gap[%0d]", g), 32'(cyc - last), 32'd2);
            last = cyc;
            @(negedge Clk);
            b.Ack = 1'b1;
            @(posedge Clk);
            #1;
            chk($sformatf("lo_drop_valid[%0d]", g), 32'(b.Valid), 32'd0);
            @(negedge Clk);
            b.Ack = 1'b0;
        end
        @(posedge Clk);
        #1;
        chk("lo_pend_empty", b.Pend, 32'h0);

`ifdef ENC_MASK_EN
        // Masked pending line must not be offered until unmasked.
        @(negedge Clk);
        a.Mask = 32'hFFFFFFEF;
        a.Req  = 32'h10;
        @(negedge Clk);
        a.Req  = '0;
        for (int k = 0; k < 10; k++) begin
            @(posedge Clk);
            #1;
            chk($sformatf("mask_valid[%0d]", k), 32'(a.Valid), 32'd0);
        end
        chk("mask_pend", a.Pend, 32'h10);
        @(negedge Clk);
        a.Mask = '1;
        @(posedge Clk);
        #1;
        chk("unmask_valid", 32'(a.Valid), 32'd1);
        chk("unmask_eout", 32'(a.Eout), 32'd4);
        @(negedge Clk);
        a.Ack = 1'b1;
        @(posedge Clk);
        #1;
        chk("unmask_clear", a.Pend, 32'h0);
        @(negedge Clk);
        a.Ack = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
